// File: rtl/dm_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
interface dm_responder_if;
    logic [6:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        err;

    modport master (
        output addr, rd, wr, wdata,
        input  rdata, rvalid, stall, err
    );

    modport slave (
        input  addr, rd, wr, wdata,
        output rdata, rvalid, stall, err
    );
endinterface

// File: rtl/dm_responder.sv
// Word-addressed data-memory responder with WAIT wait states per access.
// One request is accepted at a time; stall holds the pipeline until the access completes.
module dm_responder #(
    parameter int unsigned NMEM_WORDS = 128,
    parameter int unsigned WAIT       = 2
) (
    input  logic          clk,
    input  logic          rst,
    dm_responder_if.slave bus
);

    localparam int unsigned AW = (NMEM_WORDS > 1) ? $clog2(NMEM_WORDS) : 1;

    if (WAIT < 1 || WAIT > 15) begin : g_bad_wait
        $error("dm_responder: WAIT must be in 1..15");
    end
    if (NMEM_WORDS < 1 || NMEM_WORDS > 128) begin : g_bad_nmem
        $error("dm_responder: NMEM_WORDS must be in 1..128");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [6:0]    addr_q;
    logic [31:0]   wdata_q;
    logic          op_wr_q;
    logic          req;
    logic          conflict;
    logic          access;
    logic          mapped;
    logic [AW-1:0] idx;

    // Memory contents start at zero and survive reset.
    logic [31:0]   mem [NMEM_WORDS] = '{default: '0};

    assign req      = bus.rd ^ bus.wr;
    assign conflict = bus.rd & bus.wr;
    assign access   = (state == BUSY) && (cnt == '0);
    assign mapped   = (32'(addr_q) < NMEM_WORDS);
    assign idx      = addr_q[AW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stall; DONE never re-accepts the request still on the bus.
    always_comb begin
        state_nxt = state;
        bus.stall = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    bus.stall = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                bus.stall = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst) begin
            bus.stall = 1'b0;
            state_nxt = IDLE;
        end
    end

    // Request latch, wait counter, read data and the rvalid/err pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.rvalid <= access && !op_wr_q;
            bus.err    <= (state == IDLE) && conflict;
            if ((state == IDLE) && req) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                op_wr_q <= bus.wr;
                cnt     <= 4'(WAIT - 1);
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !op_wr_q) begin
                bus.rdata <= mapped ? mem[idx] : '0;
            end
        end
    end

    // Store port; unmapped writes and writes cut short by reset are dropped.
    always_ff @(posedge clk) begin
        if (!rst && access && op_wr_q && mapped) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule
